// File: rtl/commit_pkg.sv
// Shared types for the commit tracker: FSM state encoding and the queued entry layout.
package commit_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_HALT    = 2'd2,
    ST_TIMEOUT = 2'd3
  } commit_state_t;

  // Entry layout for the default 32-bit pc; the queue stores it flat as {ebreak, inst, pc}.
  localparam int ENTRY_XLEN = 32;

  typedef struct packed {
    logic [ENTRY_XLEN-1:0] pc;
    logic [31:0]           inst;
    logic                  ebreak;
  } commit_entry_t;

endpackage

// File: rtl/commit_fifo.sv
// Circular buffer taking up to NPUSH pre-compacted entries per cycle and popping one.
module commit_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 65,
  parameter int NPUSH = 2,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH),
  localparam int NW   = $clog2(NPUSH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NW-1:0]        push_cnt,
  input  logic [NPUSH*W-1:0]   push_data,
  input  logic                 pop,
  output logic [W-1:0]         head,
  output logic [CW-1:0]        count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Storage is not reset; the caller never trusts head while count is zero.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NPUSH; i++) begin
      if (NW'(i) < push_cnt) begin
        mem[wr_ptr + PW'(i)] <= push_data[i*W +: W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_cnt);
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_cnt) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/commit_queue.sv
// Retire-to-harness commit tracker: lane compaction, ebreak truncation, halt/timeout FSM, counters.
module commit_queue
  import commit_pkg::*;
#(
  parameter int NCOMMIT = 2,
  parameter int DEPTH   = 16,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NCOMMIT-1:0]    in_valid,
  input  logic [NCOMMIT*XLEN-1:0] in_pc,
  input  logic [NCOMMIT*32-1:0] in_inst,
  input  logic [NCOMMIT-1:0]    in_ebreak,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [XLEN-1:0]       out_pc,
  output logic [31:0]           out_inst,
  output logic                  out_ebreak,
  input  logic                  out_ready,
  output logic [63:0]           instret,
  output logic [63:0]           cycle,
  output logic                  halted,
  output logic                  timeout,
  output logic                  overflow,
  output logic [1:0]            state
);

  localparam int W  = XLEN + 33;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(NCOMMIT + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  commit_state_t      st;
  logic [CW-1:0]      count;
  logic [W-1:0]       head;
  logic [NCOMMIT*W-1:0] push_data;
  logic [NW-1:0]      kept;
  logic [NW-1:0]      push_cnt;
  logic               hit;
  logic               accept;
  logic               pop;
  logic               overflow_evt;
  logic [IW-1:0]      idle;

  // Valid lanes pack into consecutive slots; the first ebreak lane ends the group.
  always_comb begin
    push_data = '0;
    kept      = '0;
    hit       = 1'b0;
    for (int i = 0; i < NCOMMIT; i++) begin
      if (in_valid[i] && !hit) begin
        push_data[kept*W +: W] = {in_ebreak[i], in_inst[i*32 +: 32], in_pc[i*XLEN +: XLEN]};
        kept = kept + 1'b1;
        hit  = in_ebreak[i];
      end
    end
  end

  assign in_ready     = (st == ST_RUN) && ((CW'(DEPTH) - count) >= CW'(NCOMMIT));
  assign push_cnt     = in_ready ? kept : '0;
  assign accept       = in_ready && (kept != '0);
  assign out_valid    = (count != '0);
  assign pop          = out_valid && out_ready;
  assign overflow_evt = (st == ST_RUN) && !in_ready && (|in_valid);

  commit_fifo #(.DEPTH(DEPTH), .W(W), .NPUSH(NCOMMIT)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push_cnt  (push_cnt),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign out_pc     = out_valid ? head[XLEN-1:0]       : '0;
  assign out_inst   = out_valid ? head[XLEN +: 32]     : '0;
  assign out_ebreak = out_valid ? head[W-1]            : 1'b0;
  assign state      = st;

  always_ff @(posedge clock) begin
    if (reset) begin
      st       <= ST_RUN;
      instret  <= '0;
      cycle    <= '0;
      idle     <= '0;
      halted   <= 1'b0;
      timeout  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (pop) instret <= instret + 64'd1;
      if (st == ST_RUN || st == ST_DRAIN) cycle <= cycle + 64'd1;
      if (overflow_evt) overflow <= 1'b1;
      if (accept) idle <= '0;
      else if (st == ST_RUN) idle <= idle + 1'b1;
      // Idle reaching TIMEOUT this edge means it sits one below before the increment.
      if (pop && head[W-1]) begin
        st     <= ST_HALT;
        halted <= 1'b1;
      end else if (st == ST_RUN) begin
        if (accept && hit) begin
          st <= ST_DRAIN;
        end else if (!accept && idle == IW'(TIMEOUT - 1)) begin
          st      <= ST_TIMEOUT;
          timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_commit_queue.sv
// Randomized and directed bench for commit_queue against a queue-based reference model.
module tb_commit_queue;
  import commit_pkg::*;

  localparam int NCOMMIT = 2;
  localparam int DEPTH   = 16;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 4096;

  logic                      clock;
  logic                      reset;
  logic [NCOMMIT-1:0]        in_valid;
  logic [NCOMMIT*XLEN-1:0]   in_pc;
  logic [NCOMMIT*32-1:0]     in_inst;
  logic [NCOMMIT-1:0]        in_ebreak;
  logic                      in_ready;
  logic                      out_valid;
  logic [XLEN-1:0]           out_pc;
  logic [31:0]               out_inst;
  logic                      out_ebreak;
  logic                      out_ready;
  logic [63:0]               instret;
  logic [63:0]               cycle;
  logic                      halted;
  logic                      timeout;
  logic                      overflow;
  logic [1:0]                state;

  commit_queue #(.NCOMMIT(NCOMMIT), .DEPTH(DEPTH), .XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_pc      (in_pc),
    .in_inst    (in_inst),
    .in_ebreak  (in_ebreak),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_inst   (out_inst),
    .out_ebreak (out_ebreak),
    .out_ready  (out_ready),
    .instret    (instret),
    .cycle      (cycle),
    .halted     (halted),
    .timeout    (timeout),
    .overflow   (overflow),
    .state      (state)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: the queue itself plus the architectural flags and counters.
  commit_entry_t  m_q[$];
  commit_state_t  m_state;
  logic [63:0]    m_instret;
  logic [63:0]    m_cycle;
  int             m_idle;
  bit             m_halted;
  bit             m_timeout;
  bit             m_overflow;

  task automatic model_reset();
    m_q.delete();
    m_state    = ST_RUN;
    m_instret  = '0;
    m_cycle    = '0;
    m_idle     = 0;
    m_halted   = 0;
    m_timeout  = 0;
    m_overflow = 0;
  endtask

  function automatic bit model_ready();
    return (m_state == ST_RUN) && (DEPTH - m_q.size() >= NCOMMIT);
  endfunction

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    commit_entry_t acc[$];
    commit_entry_t e;
    commit_entry_t popped;
    bit ready;
    bit pop;
    ready  = model_ready();
    pop    = (m_q.size() > 0) && out_ready;
    popped = '0;
    if (ready) begin
      for (int i = 0; i < NCOMMIT; i++) begin
        if (in_valid[i]) begin
          e.pc     = in_pc[i*XLEN +: XLEN];
          e.inst   = in_inst[i*32 +: 32];
          e.ebreak = in_ebreak[i];
          acc.push_back(e);
          if (in_ebreak[i]) break;
        end
      end
    end
    if (m_state == ST_RUN && !ready && (|in_valid)) m_overflow = 1;
    if (m_state == ST_RUN || m_state == ST_DRAIN) m_cycle = m_cycle + 64'd1;
    if (pop) begin
      popped    = m_q.pop_front();
      m_instret = m_instret + 64'd1;
    end
    foreach (acc[i]) m_q.push_back(acc[i]);
    if (acc.size() > 0) m_idle = 0;
    else if (m_state == ST_RUN) m_idle++;
    if (pop && popped.ebreak) begin
      m_state  = ST_HALT;
      m_halted = 1;
    end else if (m_state == ST_RUN) begin
      if (acc.size() > 0 && acc[acc.size()-1].ebreak) m_state = ST_DRAIN;
      else if (m_idle == TIMEOUT) begin
        m_state   = ST_TIMEOUT;
        m_timeout = 1;
      end
    end
  endtask

  // Scoreboard comparison of every output against the model.
  task automatic check_all();
    check_eq("out_valid", out_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      check_eq("out_pc", out_pc, m_q[0].pc);
      check_eq("out_inst", out_inst, m_q[0].inst);
      check_eq("out_ebreak", out_ebreak, m_q[0].ebreak);
    end else begin
      check_eq("out_pc_idle", out_pc, 0);
      check_eq("out_inst_idle", out_inst, 0);
      check_eq("out_ebreak_idle", out_ebreak, 0);
    end
    check_eq("in_ready", in_ready, model_ready());
    check_eq("instret", instret, m_instret);
    check_eq("cycle", cycle, m_cycle);
    check_eq("halted", halted, m_halted);
    check_eq("timeout", timeout, m_timeout);
    check_eq("overflow", overflow, m_overflow);
    check_eq("state", state, m_state);
  endtask

  // Driver tasks
  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    check_all();
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic [1:0] eb);
    in_valid  = v;
    in_pc     = {pc1, pc0};
    in_inst   = {pc1 ^ 32'h0000_0013, pc0 ^ 32'h0000_0013};
    in_ebreak = eb;
  endtask

  task automatic drive_random(input int eb_odds);
    logic [1:0] eb;
    eb[0] = ($urandom_range(0, eb_odds) == 0);
    eb[1] = ($urandom_range(0, eb_odds) == 0);
    in_valid  = 2'($urandom_range(0, 3));
    in_pc     = {$urandom(), $urandom()};
    in_inst   = {$urandom(), $urandom()};
    in_ebreak = eb;
  endtask

  task automatic idle_inputs();
    drive(2'b00, 32'h0, 32'h0, 2'b00);
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clock);
    #1;

    // Reset values
    do_reset();
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);

    // Two lanes in order, popped on consecutive cycles
    out_ready = 1'b1;
    drive(2'b11, 32'h8000_0000, 32'h8000_0004, 2'b00);
    step();
    check_eq("t1_first_pc", out_pc, 32'h8000_0000);
    idle_inputs();
    step();
    check_eq("t1_second_pc", out_pc, 32'h8000_0004);
    step();
    check_eq("t1_instret", instret, 2);

    // Lane 1 only: no gap slot
    out_ready = 1'b0;
    drive(2'b10, 32'h0, 32'h100, 2'b00);
    step();
    check_eq("t2_pc", out_pc, 32'h100);
    idle_inputs();
    out_ready = 1'b1;
    step();
    check_eq("t2_empty", out_valid, 0);

    // Fill to DEPTH, then overflow
    do_reset();
    out_ready = 1'b0;
    for (int g = 0; g < DEPTH / NCOMMIT; g++) begin
      drive(2'b11, 32'h1000 + 32'(g * 8), 32'h1004 + 32'(g * 8), 2'b00);
      step();
    end
    check_eq("full_in_ready", in_ready, 0);
    drive(2'b11, 32'hdead_0000, 32'hdead_0004, 2'b00);
    step();
    check_eq("full_overflow", overflow, 1);
    idle_inputs();
    out_ready = 1'b1;
    repeat (2) step();
    check_eq("cnt14_in_ready", in_ready, 1);
    drive(2'b11, 32'h2000, 32'h2004, 2'b00);
    step();
    check_eq("cnt15_in_ready", in_ready, 0);
    // Pointer wrap with order preserved
    for (int c = 0; c < 40; c++) begin
      drive_random(1000);
      in_ebreak = 2'b00;
      step();
    end

    // Ebreak on lane 0 truncates lane 1
    do_reset();
    out_ready = 1'b0;
    drive(2'b11, 32'h300, 32'h304, 2'b01);
    step();
    check_eq("eb_state", state, 2'(ST_DRAIN));
    check_eq("eb_in_ready", in_ready, 0);
    drive(2'b11, 32'h400, 32'h404, 2'b00);
    step();
    check_eq("eb_drain_no_overflow", overflow, 0);
    idle_inputs();
    out_ready = 1'b1;
    step();
    check_eq("eb_halted", halted, 1);
    check_eq("eb_instret", instret, 1);
    check_eq("eb_lane1_unseen", out_valid, 0);

    // Randomized segments
    for (int s = 0; s < 6; s++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        drive_random(40);
        out_ready = ($urandom_range(0, 3) != 0);
        step();
      end
    end

    // Timeout after TIMEOUT idle cycles, then reset from TIMEOUT
    do_reset();
    idle_inputs();
    out_ready = 1'b1;
    repeat (TIMEOUT - 1) step();
    check_eq("to_not_yet", timeout, 0);
    step();
    check_eq("to_set", timeout, 1);
    check_eq("to_cycle", cycle, 64'(TIMEOUT));
    repeat (5) step();
    do_reset();
    check_eq("to_rst_timeout", timeout, 0);
    check_eq("to_rst_cycle", cycle, 0);
    check_eq("to_rst_state", state, 2'(ST_RUN));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
